// File: rtl/salamander_pkg.sv
// Shared types and default widths for the salamander 4-bit core control path.
package salamander_pkg;

  localparam int DEF_INSTR_W = 8;
  localparam int DEF_OPC_W   = 4;

  typedef enum logic [3:0] {
    OPC_NOP    = 4'h0,
    OPC_ALU_LO = 4'h1,
    OPC_ALU_HI = 4'h7,
    OPC_JZ     = 4'h8,
    OPC_JMPF   = 4'h9,
    OPC_HALT   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational instruction decode: opcode class flags and the PC increment amount.
module pc_seq_decode
  import salamander_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
) (
  input  logic [INSTR_W-1:0] ir,
  input  logic               zero_flag,
  output logic [OPC_W-1:0]   alu_op,
  output logic               is_alu,
  output logic               is_halt,
  output logic [ADDR_W-1:0]  inc_val
);

  localparam int OPD_W = INSTR_W - OPC_W;

  logic [OPC_W-1:0]  opcode;
  logic [OPD_W-1:0]  operand;
  logic [ADDR_W-1:0] opdExt;

  assign opcode  = ir[INSTR_W-1 -: OPC_W];
  assign operand = ir[OPD_W-1:0];
  assign opdExt  = ADDR_W'(operand);

  assign alu_op  = opcode;
  assign is_alu  = (opcode >= OPC_W'(OPC_ALU_LO)) && (opcode <= OPC_W'(OPC_ALU_HI));
  assign is_halt = (opcode == OPC_W'(OPC_HALT));

  // A zero jump distance would spin on the same address, so it degrades to a step of 1.
  always_comb begin
    inc_val = ADDR_W'(1);
    if (opcode == OPC_W'(OPC_JZ)) begin
      if (zero_flag && (operand != '0)) inc_val = opdExt;
    end else if ((opcode == OPC_W'(OPC_JMPF)) && (operand != '0)) begin
      inc_val = opdExt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit core.
// Define PC_SEQ_FETCH_TIMEOUT_EN to build the fetch watchdog that faults a stalled fetch.
module pc_sequencer
  import salamander_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int OPC_W       = DEF_OPC_W,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_val,
  input  logic               pc_max_reached,
  input  logic               zero_flag,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               pc_inc,
  output logic [ADDR_W-1:0]  pc_inc_val,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] ir,
  output logic [OPC_W-1:0]   alu_op,
  output logic               alu_en,
  output logic               acc_we,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  if (TIMEOUT_CYC < 1) begin : g_badTimeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [OPC_W-1:0]   aluOp_q, aluOp_d;
  logic [ADDR_W-1:0]  incVal_q, incVal_d;

  logic [OPC_W-1:0]   decAluOp;
  logic               decIsAlu;
  logic               decIsHalt;
  logic [ADDR_W-1:0]  decIncVal;
  logic               fetchReq;
  logic               timeout;

  pc_seq_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) u_decode (
    .ir        (ir_q),
    .zero_flag (zero_flag),
    .alu_op    (decAluOp),
    .is_alu    (decIsAlu),
    .is_halt   (decIsHalt),
    .inc_val   (decIncVal)
  );

  // pc_val is stable for the whole fetch, so checking the wrap flag every cycle equals an entry check.
  assign fetchReq = (state_q == ST_FETCH) && !pc_max_reached;

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
  localparam int WdW = $clog2(TIMEOUT_CYC + 1);

  logic [WdW-1:0] wdCnt_q, wdCnt_d;
  logic           fault_q, fault_d;

  // Counts unanswered fetch cycles; an ack in the last allowed cycle still wins.
  always_comb begin
    wdCnt_d = '0;
    if (fetchReq && !imem_ack) wdCnt_d = wdCnt_q + 1'b1;
  end

  assign timeout = fetchReq && !imem_ack && (wdCnt_q == WdW'(TIMEOUT_CYC - 1));
  assign fault_d = fault_q | timeout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdCnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      wdCnt_q <= wdCnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    aluOp_d  = aluOp_q;
    incVal_d = incVal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pc_max_reached) begin
          state_d = ST_HALT;
        end else if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        aluOp_d = decAluOp;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Latched here so a conditional jump sees the flag produced by this instruction's execute cycle.
        incVal_d = decIncVal;
        state_d  = ST_WB;
      end
      ST_WB: begin
        state_d = decIsHalt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      aluOp_q  <= '0;
      incVal_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      aluOp_q  <= aluOp_d;
      incVal_q <= incVal_d;
    end
  end

  assign imem_req   = fetchReq;
  assign imem_addr  = fetchReq ? pc_val : '0;
  assign ir         = ir_q;
  assign alu_op     = aluOp_q;
  assign alu_en     = (state_q == ST_EXEC) && decIsAlu;
  assign acc_we     = (state_q == ST_WB) && decIsAlu;
  assign pc_inc     = (state_q == ST_WB) && !decIsHalt;
  assign pc_inc_val = pc_inc ? incVal_q : '0;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_WB);
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus random programs against an instruction-level model.
module tb_pc_sequencer;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int TIMEOUT = 15;

  logic               clk;
  logic               rstn;
  logic               start;
  logic [ADDR_W-1:0]  pc_val;
  logic               pc_max_reached;
  logic               zero_flag;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc_inc_val;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] ir;
  logic [OPC_W-1:0]   alu_op;
  logic               alu_en;
  logic               acc_we;
  logic               busy;
  logic               halted;
  logic               fault;

  int checkCount;
  int failCount;

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .INSTR_W     (INSTR_W),
    .OPC_W       (OPC_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .pc_val         (pc_val),
    .pc_max_reached (pc_max_reached),
    .zero_flag      (zero_flag),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .pc_inc         (pc_inc),
    .pc_inc_val     (pc_inc_val),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .ir             (ir),
    .alu_op         (alu_op),
    .alu_en         (alu_en),
    .acc_we         (acc_we),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // PC step the specification assigns to an instruction, given the zero flag seen in execute.
  function automatic logic [ADDR_W-1:0] refInc(input logic [INSTR_W-1:0] instr, input logic zf);
    int opc;
    int opd;
    opc = int'(instr[7:4]);
    opd = int'(instr[3:0]);
    if (opc == 8) return (zf && opd != 0) ? ADDR_W'(opd) : ADDR_W'(1);
    if (opc == 9) return (opd != 0) ? ADDR_W'(opd) : ADDR_W'(1);
    return ADDR_W'(1);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pc_inc"}, pc_inc, 0);
    checkOutput({tag, "_pc_inc_val"}, pc_inc_val, 0);
    checkOutput({tag, "_imem_req"}, imem_req, 0);
    checkOutput({tag, "_imem_addr"}, imem_addr, 0);
    checkOutput({tag, "_ir"}, ir, 0);
    checkOutput({tag, "_alu_op"}, alu_op, 0);
    checkOutput({tag, "_alu_en"}, alu_en, 0);
    checkOutput({tag, "_acc_we"}, acc_we, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_halted"}, halted, 0);
    checkOutput({tag, "_fault"}, fault, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    start = 1'b0;
    pc_val = '0;
    pc_max_reached = 1'b0;
    zero_flag = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkAllZero("post_reset");
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first FETCH cycle.
  task automatic startRun();
    @(negedge clk);
    start = 1'b1;
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_halted", halted, 0);
    @(negedge clk);
  endtask

  task automatic checkHalted(input string tag);
    #1;
    checkOutput({tag, "_halted"}, halted, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_imem_req"}, imem_req, 0);
    checkOutput({tag, "_pc_inc"}, pc_inc, 0);
  endtask

  // One instruction from the start of its fetch: delay wait cycles, then decode, execute, writeback.
  task automatic applyStimulus(input logic [INSTR_W-1:0] instr, input int delay, input logic zf);
    logic [3:0]        opc;
    logic              isAlu;
    logic              isHalt;
    logic [ADDR_W-1:0] expInc;
    opc    = instr[7:4];
    isAlu  = (opc >= 4'h1) && (opc <= 4'h7);
    isHalt = (opc == 4'hF);
    expInc = refInc(instr, zf);
    for (int w = 0; w <= delay; w++) begin
      imem_ack  = (w == delay);
      imem_data = (w == delay) ? instr : INSTR_W'($urandom);
      start     = 1'($urandom);
      zero_flag = 1'($urandom);
      #1;
      checkOutput("fetch_req", imem_req, 1);
      checkOutput("fetch_addr", imem_addr, pc_val);
      checkOutput("fetch_busy", busy, 1);
      checkOutput("fetch_pc_inc", pc_inc, 0);
      checkOutput("fetch_fault", fault, 0);
      @(negedge clk);
    end
    imem_ack  = 1'($urandom);
    imem_data = INSTR_W'($urandom);
    zero_flag = 1'($urandom);
    #1;
    checkOutput("decode_ir", ir, instr);
    checkOutput("decode_req", imem_req, 0);
    checkOutput("decode_alu_en", alu_en, 0);
    checkOutput("decode_acc_we", acc_we, 0);
    checkOutput("decode_pc_inc", pc_inc, 0);
    checkOutput("decode_busy", busy, 1);
    @(negedge clk);
    zero_flag = zf;
    #1;
    checkOutput("exec_alu_op", alu_op, opc);
    checkOutput("exec_alu_en", alu_en, isAlu);
    checkOutput("exec_acc_we", acc_we, 0);
    checkOutput("exec_pc_inc", pc_inc, 0);
    @(negedge clk);
    zero_flag = 1'($urandom);
    #1;
    checkOutput("wb_acc_we", acc_we, isAlu);
    checkOutput("wb_alu_en", alu_en, 0);
    checkOutput("wb_pc_inc", pc_inc, !isHalt);
    checkOutput("wb_pc_inc_val", pc_inc_val, isHalt ? '0 : expInc);
    checkOutput("wb_busy", busy, 1);
    if (!isHalt) pc_val = pc_val + expInc;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rstn = 1'b0;
    start = 1'b0;
    pc_val = '0;
    pc_max_reached = 1'b0;
    zero_flag = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;

    doReset();
    startRun();
    applyStimulus(8'h00, 0, 1'b0);
    checkOutput("nop_next_addr", pc_val, 1);
    applyStimulus(8'hF0, 0, 1'b0);
    checkHalted("nop_halt");
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      @(negedge clk);
      checkHalted("halt_sticky");
    end

    doReset();
    startRun();
    applyStimulus(8'h35, 3, 1'b0);
    applyStimulus(8'h84, 0, 1'b1);
    applyStimulus(8'h84, 2, 1'b0);
    applyStimulus(8'h90, 1, 1'b1);
    applyStimulus(8'h93, 0, 1'b0);
    applyStimulus(8'h80, 0, 1'b1);
    applyStimulus(8'hA7, 0, 1'b1);
    applyStimulus(8'hF3, 1, 1'b0);
    checkHalted("directed_halt");

    for (int r = 0; r < 3; r++) begin
      doReset();
      startRun();
      for (int i = 0; i < 40; i++) begin
        logic [INSTR_W-1:0] instr;
        instr[7:4] = 4'($urandom_range(0, 14));
        instr[3:0] = 4'($urandom);
        applyStimulus(instr, int'($urandom_range(0, 6)), 1'($urandom));
      end
      applyStimulus(8'hF0, int'($urandom_range(0, 3)), 1'b0);
      checkHalted("random_halt");
    end

    doReset();
    pc_max_reached = 1'b1;
    startRun();
    start = 1'b0;
    imem_ack = 1'b1;
    #1;
    checkOutput("max_entry_req", imem_req, 0);
    checkOutput("max_entry_addr", imem_addr, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    checkHalted("max_halt");
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      checkHalted("max_start_ignored");
    end
    rstn = 1'b0;
    start = 1'b0;
    #1;
    checkAllZero("max_rst");
    @(negedge clk);
    rstn = 1'b1;

    doReset();
    startRun();
    applyStimulus(8'h10, 0, 1'b0);
    pc_max_reached = 1'b1;
    #1;
    checkOutput("max_mid_req", imem_req, 0);
    @(negedge clk);
    checkHalted("max_mid_halt");

    doReset();
    startRun();
    start = 1'b0;
    imem_ack = 1'b1;
    imem_data = 8'h35;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_exec_alu_en", alu_en, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("rst_exec");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkAllZero("rst_exec_hold");
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkAllZero("rst_exec_idle");
    end
    pc_val = '0;
    startRun();
    applyStimulus(8'h42, 1, 1'b0);
    applyStimulus(8'hF0, 0, 1'b0);
    checkHalted("rst_recover_halt");

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    doReset();
    startRun();
    start = 1'b0;
    for (int w = 0; w < TIMEOUT; w++) begin
      imem_ack = 1'b0;
      #1;
      checkOutput("wd_wait_req", imem_req, 1);
      checkOutput("wd_wait_fault", fault, 0);
      @(negedge clk);
    end
    #1;
    checkOutput("wd_fault", fault, 1);
    checkHalted("wd_halt");
    doReset();
    startRun();
    applyStimulus(8'h21, TIMEOUT - 1, 1'b0);
    #1;
    checkOutput("wd_ack_wins_fault", fault, 0);
    checkOutput("wd_ack_wins_busy", busy, 1);
    applyStimulus(8'hF0, 0, 1'b0);
    checkHalted("wd_ack_halt");
`else
    doReset();
    startRun();
    start = 1'b0;
    for (int w = 0; w < 3 * TIMEOUT; w++) begin
      imem_ack = 1'b0;
      #1;
      checkOutput("nowd_wait_req", imem_req, 1);
      checkOutput("nowd_fault", fault, 0);
      @(negedge clk);
    end
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'hF0, 0, 1'b0);
    checkHalted("nowd_halt");
    checkOutput("nowd_fault_end", fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/execute control FSM for the 4-bit core.
- Drives the program counter's `inc` and `inc_val` inputs and issues instruction-memory reads at the current PC.
- Latches the instruction register and issues one-cycle ALU-enable and accumulator-write strobes.
- Sits between the program counter, the instruction memory and the ALU/accumulator datapath.

Parameters:
- ADDR_W, 5, PC/instruction address width; matches the program counter SIZE.
- INSTR_W, 8, instruction width.
- OPC_W, 4, opcode field width (instruction bits [INSTR_W-1 -: OPC_W]); the operand is the low INSTR_W-OPC_W bits.
- TIMEOUT_CYC, 15, fetch watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  begin execution from IDLE.
- pc_val  input  ADDR_W  current program counter value.
- pc_max_reached  input  1  program counter wrap flag.
- zero_flag  input  1  accumulator-zero flag from the datapath.
- imem_ack  input  1  instruction-memory data valid.
- imem_data  input  INSTR_W  fetched instruction.
- pc_inc  output  1  one-cycle PC increment strobe.
- pc_inc_val  output  ADDR_W  PC increment amount, valid while pc_inc=1.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address.
- ir  output  INSTR_W  instruction register.
- alu_op  output  OPC_W  ALU operation code.
- alu_en  output  1  one-cycle ALU execute strobe.
- acc_we  output  1  one-cycle accumulator write strobe.
- busy  output  1  high in FETCH, DECODE, EXEC and WB.
- halted  output  1  high in HALT.
- fault  output  1  fetch timeout; sticky until reset.

Behaviour:
- Reset (async, rstn=0): state=IDLE; every output 0; ir=0; watchdog counter=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. The state is registered; all outputs are registered or decoded from state/ir only, with no combinational path from imem inputs.
- IDLE: on start=1 go to FETCH. Otherwise stay.
- FETCH entry check: if pc_max_reached=1, go to HALT and do not request.
- FETCH: otherwise imem_req=1 and imem_addr=pc_val.
  - imem_ack is sampled at the clock edge.
  - On ack: ir<=imem_data, go to DECODE.
  - Without ack: stay; the request stays held.
- DECODE (1 cycle): alu_op <= opcode; compute the next increment amount.
- EXEC (1 cycle): alu_en=1 only for ALU opcodes 0x1-0x7.
- WB (1 cycle):
  - acc_we=1 for ALU opcodes only.
  - pc_inc=1 with pc_inc_val per the opcode rules below.
  - Next state is FETCH, or HALT for the HALT opcode (HALT issues no pc_inc).
- Opcodes:
  - 0x0 NOP: inc_val 1.
  - 0x1-0x7 ALU: inc_val 1.
  - 0x8 JZ: inc_val = operand if zero_flag (sampled in EXEC) is 1 and operand is nonzero, else 1.
  - 0x9 JMPF: inc_val = operand, or 1 if operand is 0 (no self-loop).
  - 0xA-0xE reserved: executed as NOP.
  - 0xF HALT: go to HALT.
- Operand is zero-extended to ADDR_W.
- Minimum instruction latency is 4 cycles (ack in the first FETCH cycle); each extra wait cycle adds 1.
- HALT is sticky: start is ignored, and only rstn exits.
- start while busy: ignored.
- rstn asserted mid-instruction: immediate return to IDLE with all strobes low; no partial pc_inc is emitted.
- pc_inc is never high for more than one consecutive cycle. alu_en and acc_we are never high in the same cycle.

Optional Feature:
- Macro: PC_SEQ_FETCH_TIMEOUT_EN.
- With the macro: a watchdog counter runs while FETCH is waiting.
  - It resets to 0 on FETCH entry.
  - If TIMEOUT_CYC cycles pass without imem_ack: fault<=1, imem_req drops, state goes to HALT.
  - If ack arrives in exactly cycle TIMEOUT_CYC, the ack wins.
- Without the macro: no counter is built, fault is tied 0, and FETCH waits indefinitely.

Decomposition:
- Shared package salamander_pkg holds:
  - the opcode enum (NOP, ALU range bounds, JZ, JMPF, HALT);
  - the seq_state_t enum;
  - the OPC_W and INSTR_W defaults.
- One sub-module, pc_seq_decode, is combinational. It takes ir and zero_flag and returns alu_op, is_alu, is_halt and inc_val.

Test Plan:
- Reset then start=1 with ack in the same cycle, program NOP,HALT (0x00,0xF0): pc_inc seen once with inc_val 1; halted=1 after 8 cycles; imem_addr 0 then 1.
- ALU op 0x35 with ack delayed 3 cycles: imem_req held 4 cycles; alu_op=3; alu_en pulse in EXEC then acc_we pulse in WB; pc_inc_val=1.
- JZ 0x84:
  - zero_flag=1 gives pc_inc_val=4.
  - zero_flag=0 gives pc_inc_val=1.
  - JMPF 0x90 gives pc_inc_val=1.
- pc_max_reached=1 on FETCH entry: no imem_req and halted=1. start pulses afterwards are ignored; rstn low returns to IDLE with all outputs 0.
- rstn low during EXEC of an ALU op: no acc_we and no pc_inc. After release, state is IDLE and busy=0.
- With PC_SEQ_FETCH_TIMEOUT_EN and no ack: fault=1 and halted=1 after 15 wait cycles. An ack at cycle 15 completes the fetch with no fault. Without the macro, fault stays 0 throughout.
